// File: rtl/bf_decoder.sv
// bf_decoder: serial bit-flipping decoder for QC-MDPC decapsulation.
// Takes the syndrome and the sparse h0/h1 position lists, then visits every
// error bit once per iteration (block 0 first, then block 1, one bit per
// cycle). A bit is flipped when its unsatisfied-parity-check count reaches
// th, and the working syndrome is updated right away, so later bits see the
// effect of earlier flips. It stops on a zero syndrome (success) or after
// NITER iterations (failure).
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             one-cycle request, honoured only when idle
//   s_in              R-bit syndrome, latched on start
//   h0_pos_flat       W positions for block 0, entry i at [i*POS_W +: POS_W]
//   h1_pos_flat       W positions for block 1, same packing
//   th                flip threshold, latched on start
//   e0, e1            recovered error blocks
//   iter_cnt          number of iterations started
//   busy              high whenever the decoder is not idle
//   success           result flag, valid with done, held until next start
//   done              one-cycle completion pulse
module bf_decoder #(
  parameter int R     = 127,
  parameter int W     = 5,
  parameter int POS_W = 8,
  parameter int TH_W  = 4,
  parameter int NITER = 4,
  parameter int IT_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [R-1:0]       s_in,
  input  logic [W*POS_W-1:0] h0_pos_flat,
  input  logic [W*POS_W-1:0] h1_pos_flat,
  input  logic [TH_W-1:0]    th,
  output logic [R-1:0]       e0,
  output logic [R-1:0]       e1,
  output logic [IT_W-1:0]    iter_cnt,
  output logic               busy,
  output logic               success,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;

  state_t             state_r, state_nxt;
  logic [R-1:0]       s_reg;
  logic [W*POS_W-1:0] h0_r, h1_r;
  logic [TH_W-1:0]    th_r;
  logic [POS_W-1:0]   j_r;
  logic               blk_r;

  logic [W*POS_W-1:0] pos_s;
  logic [TH_W-1:0]    upc_s;
  logic [R-1:0]       s_mask_s;
  logic               flip_s;
  logic               last_bit_s;

  // (j + p) mod R without a divider: entries are < R, so one subtraction suffices.
  function automatic logic [POS_W-1:0] wrap_idx(input logic [POS_W-1:0] j,
                                                input logic [POS_W-1:0] p);
    logic [POS_W:0] sum;
    sum = {1'b0, j} + {1'b0, p};
    if (sum >= (POS_W+1)'(R)) begin
      sum = sum - (POS_W+1)'(R);
    end else begin
      sum = sum;
    end
    return sum[POS_W-1:0];
  endfunction

  // UPC of the current bit and the syndrome toggle mask it would apply.
  // The mask is built with XOR so duplicate positions cancel out.
  always_comb begin
    logic [POS_W-1:0] idx_v;
    logic [R-1:0]     sh_v;
    pos_s    = blk_r ? h1_r : h0_r;
    upc_s    = '0;
    s_mask_s = '0;
    idx_v    = '0;
    sh_v     = '0;
    for (int k = 0; k < W; k++) begin
      idx_v    = wrap_idx(j_r, pos_s[k*POS_W +: POS_W]);
      sh_v     = s_reg >> idx_v;
      upc_s    = upc_s + TH_W'(sh_v[0]);
      s_mask_s = s_mask_s ^ (R'(1) << idx_v);
    end
    flip_s     = (upc_s >= th_r);
    last_bit_s = blk_r && (j_r == POS_W'(R-1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (start) state_nxt = CHECK; else state_nxt = IDLE;
      CHECK:   if (s_reg == '0)                  state_nxt = DONE;
               else if (iter_cnt == IT_W'(NITER)) state_nxt = DONE;
               else                              state_nxt = SCAN;
      SCAN:    if (last_bit_s) state_nxt = CHECK; else state_nxt = SCAN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: input latching, per-bit flip/syndrome update, result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg    <= '0;
      h0_r     <= '0;
      h1_r     <= '0;
      th_r     <= '0;
      j_r      <= '0;
      blk_r    <= 1'b0;
      e0       <= '0;
      e1       <= '0;
      iter_cnt <= '0;
      success  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_nxt != IDLE);
      case (state_r)
        IDLE: begin
          if (start) begin
            s_reg    <= s_in;
            h0_r     <= h0_pos_flat;
            h1_r     <= h1_pos_flat;
            th_r     <= th;
            e0       <= '0;
            e1       <= '0;
            iter_cnt <= '0;
            success  <= 1'b0;
          end
        end
        CHECK: begin
          if (s_reg == '0) begin
            success <= 1'b1;
          end else if (iter_cnt == IT_W'(NITER)) begin
            success <= 1'b0;
          end else begin
            iter_cnt <= iter_cnt + IT_W'(1);
            j_r      <= '0;
            blk_r    <= 1'b0;
          end
        end
        SCAN: begin
          if (flip_s) begin
            s_reg <= s_reg ^ s_mask_s;
            if (blk_r) e1 <= e1 ^ (R'(1) << j_r);
            else       e0 <= e0 ^ (R'(1) << j_r);
          end
          if (j_r == POS_W'(R-1)) begin
            j_r   <= '0;
            blk_r <= ~blk_r;
          end else begin
            j_r <= j_r + POS_W'(1);
          end
        end
        DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_decoder.sv
module tb_bf_decoder;
  localparam int R = 127, W = 5, POS_W = 8, TH_W = 4, NITER = 4, IT_W = 3;

  logic               clk = 1'b0;
  logic               rst, start;
  logic [R-1:0]       s_in;
  logic [W*POS_W-1:0] h0_pos_flat, h1_pos_flat;
  logic [TH_W-1:0]    th;
  logic [R-1:0]       e0, e1;
  logic [IT_W-1:0]    iter_cnt;
  logic               busy, success, done;

  bf_decoder #(.R(R), .W(W), .POS_W(POS_W), .TH_W(TH_W), .NITER(NITER), .IT_W(IT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .s_in(s_in),
    .h0_pos_flat(h0_pos_flat), .h1_pos_flat(h1_pos_flat), .th(th),
    .e0(e0), .e1(e1), .iter_cnt(iter_cnt), .busy(busy), .success(success), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [R-1:0]    s;
    logic [TH_W-1:0] th;
    logic [R-1:0]    e0;
    logic [R-1:0]    e1;
    logic            succ;
    logic [IT_W-1:0] it;
    int              lat;
  } vec_t;

  vec_t vecs[4];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [R-1:0] bits5(input int a, b, c, d, f);
    logic [R-1:0] r;
    r = '0;
    r = r | (R'(1) << a) | (R'(1) << b) | (R'(1) << c) | (R'(1) << d) | (R'(1) << f);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_h();
    int p0[W] = '{3, 7, 11, 19, 25};
    int p1[W] = '{2, 5, 13, 17, 29};
    for (int i = 0; i < W; i++) begin
      h0_pos_flat[i*POS_W +: POS_W] = POS_W'(p0[i]);
      h1_pos_flat[i*POS_W +: POS_W] = POS_W'(p1[i]);
    end
  endtask

  // Start one decode, scramble the inputs afterwards, wait for done and score it.
  // extra_start > 0 pulses start again that many cycles into the run.
  task automatic run_vec(input vec_t v, input int extra_start);
    int   lat;
    bit   got;
    int   extra_done;
    vec_t ex;
    exp_q.push_back(v);
    @(negedge clk);
    drive_h();
    s_in  = v.s;
    th    = v.th;
    start = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    s_in        = {$urandom, $urandom, $urandom, $urandom};
    th          = '0;
    h0_pos_flat = {$urandom, $urandom};
    h1_pos_flat = {$urandom, $urandom};
    chk("busy_after_start", 128'(busy), 128'(1'b1));
    lat = 0;
    got = 1'b0;
    while (!got && lat < 1500) begin
      @(posedge clk); #1;
      lat++;
      start = (extra_start > 0 && lat == extra_start);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    ex = exp_q.pop_front();
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done after %0d cycles, expected at %0d", lat, ex.lat);
    end else begin
      chk("latency",  128'(lat),      128'(ex.lat));
      chk("e0",       128'(e0),       128'(ex.e0));
      chk("e1",       128'(e1),       128'(ex.e1));
      chk("success",  128'(success),  128'(ex.succ));
      chk("iter_cnt", 128'(iter_cnt), 128'(ex.it));
      chk("busy_at_done", 128'(busy), 128'(1'b0));
      extra_done = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (done) extra_done++;
      end
      chk("single_done_pulse", 128'(extra_done), 128'(0));
      chk("e0_held",      128'(e0),      128'(ex.e0));
      chk("success_held", 128'(success), 128'(ex.succ));
    end
  endtask

  initial begin
    // Zero syndrome: immediate success.
    vecs[0] = '{s: '0, th: 4'd4, e0: '0, e1: '0, succ: 1'b1, it: 3'd0, lat: 2};
    // Single error e0[10]: syndrome bits 10 + h0.
    vecs[1] = '{s: bits5(13, 17, 21, 29, 35), th: 4'd4, e0: R'(1) << 10, e1: '0,
                succ: 1'b1, it: 3'd1, lat: 257};
    // Single error e1[126]: 126 + h1 wraps to {1,4,12,16,28}; e0[9] sees UPC 3.
    vecs[2] = '{s: bits5(1, 4, 12, 16, 28), th: 4'd4, e0: '0, e1: R'(1) << 126,
                succ: 1'b1, it: 3'd1, lat: 257};
    // Threshold above W never flips: failure after NITER iterations.
    vecs[3] = '{s: bits5(13, 17, 21, 29, 35), th: 4'd6, e0: '0, e1: '0,
                succ: 1'b0, it: 3'd4, lat: 1022};

    rst = 1'b1; start = 1'b0; s_in = '0; th = '0;
    drive_h();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_e0",       128'(e0),       128'(0));
    chk("rst_e1",       128'(e1),       128'(0));
    chk("rst_iter_cnt", 128'(iter_cnt), 128'(0));
    chk("rst_busy",     128'(busy),     128'(0));
    chk("rst_success",  128'(success),  128'(0));
    chk("rst_done",     128'(done),     128'(0));
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], 0);

    // Second start in the middle of SCAN must be ignored.
    run_vec(vecs[1], 30);

    // Reset in the middle of SCAN, after e0[10] has already flipped.
    @(negedge clk);
    drive_h();
    s_in = vecs[1].s; th = vecs[1].th; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_e0",       128'(e0),       128'(0));
    chk("midrst_iter_cnt", 128'(iter_cnt), 128'(0));
    chk("midrst_busy",     128'(busy),     128'(0));
    @(posedge clk); #1;
    chk("midrst_busy_hold", 128'(busy),    128'(0));
    chk("midrst_done",      128'(done),    128'(0));
    chk("midrst_success",   128'(success), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
